// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: mode encodings, underrun word and FSM states.
package spi_pkg;

    localparam bit CPOL_IDLE_LOW  = 1'b0;
    localparam bit CPOL_IDLE_HIGH = 1'b1;
    localparam bit CPHA_LEADING   = 1'b0;
    localparam bit CPHA_TRAILING  = 1'b1;

    localparam logic [7:0] SPI_DEFAULT_TX = 8'hFF;

    typedef enum logic [1:0] {
        ARMED_WAIT,
        IDLE,
        LOAD,
        SHIFT
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall event pulses.
module spi_sync_edge #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
        end
    end

    // Events are acted on one clk after the level settles, giving STAGES+1 total latency.
    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_if.sv
// Oversampled SPI responder: receives MOSI words into rx_data and shifts tx_data out on MISO.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter bit                    CPOL        = CPOL_IDLE_HIGH,
    parameter bit                    CPHA        = CPHA_TRAILING,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = DATA_WIDTH'(SPI_DEFAULT_TX),
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_rise, sclk_fall, unused_sclk_level;
    logic cs_level, cs_fall, unused_cs_rise;
    logic mosi_level, unused_mosi_rise, unused_mosi_fall;

    // cs_n resets to "asserted" so a frame already in progress at reset release is never seen as a new one.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
        .clk(clk), .reset(reset), .pin(sclk),
        .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk(clk), .reset(reset), .pin(cs_n),
        .level(cs_level), .rise(unused_cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .pin(mosi),
        .level(mosi_level), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    logic lead_evt, trail_evt, shift_evt, sample_evt;
    assign lead_evt   = CPOL ? sclk_fall : sclk_rise;
    assign trail_evt  = CPOL ? sclk_rise : sclk_fall;
    assign shift_evt  = CPHA ? lead_evt  : trail_evt;
    assign sample_evt = CPHA ? trail_evt : lead_evt;

    spi_state_t            state;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, hold_data, next_word;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  hold_full, word_done;

    assign tx_ready  = ~hold_full;
    assign next_word = hold_full ? hold_data : DEFAULT_TX;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARMED_WAIT;
            tx_sr       <= '0;
            rx_sr       <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            tx_underrun <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            rx_valid    <= 1'b0;
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
            case (state)
                ARMED_WAIT: begin
                    if (cs_level) state <= IDLE;
                end
                IDLE: begin
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    if (cs_fall) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cs_level) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state       <= SHIFT;
                        miso_oe     <= 1'b1;
                        bit_cnt     <= '0;
                        tx_underrun <= ~hold_full;
                        if (hold_full) hold_full <= 1'b0;
                        // CPHA=0 must present the MSB before the first leading edge.
                        if (!CPHA) begin
                            miso  <= next_word[DATA_WIDTH-1];
                            tx_sr <= next_word << 1;
                        end else begin
                            tx_sr <= next_word;
                        end
                    end
                end
                SHIFT: begin
                    // In CPHA=0 the trailing edge after the last sample belongs to the finished word.
                    if (shift_evt && (CPHA || bit_cnt != '0)) begin
                        miso  <= tx_sr[DATA_WIDTH-1];
                        tx_sr <= tx_sr << 1;
                    end
                    if (sample_evt) begin
                        rx_sr   <= {rx_sr[DATA_WIDTH-2:0], mosi_level};
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    end
                    if (word_done) begin
                        word_done <= 1'b0;
                        rx_data   <= rx_sr;
                        rx_valid  <= 1'b1;
                        if (cs_level) begin
                            state   <= IDLE;
                            miso_oe <= 1'b0;
                            busy    <= 1'b0;
                            miso    <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (sample_evt && bit_cnt == LAST_BIT) begin
                        word_done <= 1'b1;
                    end else if (cs_level) begin
                        state   <= IDLE;
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        miso    <= 1'b0;
                    end
                end
                default: state <= ARMED_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: mode-3 instance (dut_a) and a CPHA=0 instance (dut_b).
module tb_spi_slave_if;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       sclk_a = 1'b1, cs_n_a = 1'b1, mosi_a = 1'b0, tx_valid_a = 1'b0;
    logic [7:0] tx_data_a = 8'h00;
    logic       miso_a, miso_oe_a, tx_ready_a, tx_underrun_a, rx_valid_a, busy_a;
    logic [7:0] rx_data_a;

    logic       sclk_b = 1'b1, cs_n_b = 1'b1, mosi_b = 1'b0, tx_valid_b = 1'b0;
    logic [7:0] tx_data_b = 8'h00;
    logic       miso_b, miso_oe_b, tx_ready_b, tx_underrun_b, rx_valid_b, busy_b;
    logic [7:0] rx_data_b;

    spi_slave_if #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .DEFAULT_TX(8'hFF), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(rst), .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a),
        .miso(miso_a), .miso_oe(miso_oe_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .tx_underrun(tx_underrun_a), .rx_data(rx_data_a),
        .rx_valid(rx_valid_a), .busy(busy_a)
    );

    spi_slave_if #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b0), .DEFAULT_TX(8'hFF), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(rst), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b),
        .miso(miso_b), .miso_oe(miso_oe_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .tx_underrun(tx_underrun_b), .rx_data(rx_data_b),
        .rx_valid(rx_valid_b), .busy(busy_b)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];
    int         rx_cnt_a = 0;
    int         unr_cnt_a = 0;
    bit         oe_seen_a = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_valid pulse consumes one expected word from its queue.
    always @(negedge clk) begin
        if (rx_valid_a) begin
            rx_cnt_a++;
            if (exp_a_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_a_unexpected: got %0h expected none", rx_data_a);
            end else begin
                check("rx_a_word", 32'(rx_data_a), 32'(exp_a_q.pop_front()));
            end
        end
        if (rx_valid_b) begin
            if (exp_b_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_b_unexpected: got %0h expected none", rx_data_b);
            end else begin
                check("rx_b_word", 32'(rx_data_b), 32'(exp_b_q.pop_front()));
            end
        end
        if (tx_underrun_a) unr_cnt_a++;
        if (miso_oe_a) oe_seen_a = 1'b1;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [7:0] d);
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        for (int n = 0; n < 200 && !tx_ready_a; n++) clks(1);
        check("tx_a_accept", 32'(tx_ready_a), 32'd1);
        clks(1);
        tx_valid_a = 1'b0;
    endtask

    task automatic b_write(input logic [7:0] d);
        tx_data_b  = d;
        tx_valid_b = 1'b1;
        for (int n = 0; n < 200 && !tx_ready_b; n++) clks(1);
        check("tx_b_accept", 32'(tx_ready_b), 32'd1);
        clks(1);
        tx_valid_b = 1'b0;
    endtask

    // Mode 3 master: change mosi on the falling (leading) edge, read miso at the rising edge.
    task automatic a_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            clks(4);
            sclk_a = 1'b0;
            mosi_a = mo[i];
            clks(4);
            mi[i]  = miso_a;
            sclk_a = 1'b1;
        end
    endtask

    task automatic a_frame(input logic [7:0] mo, output logic [7:0] mi);
        exp_a_q.push_back(mo);
        cs_n_a = 1'b0;
        clks(4);
        a_bits(mo, 8, mi);
        clks(1);
        cs_n_a = 1'b1;
        clks(8);
    endtask

    logic [7:0] mi, m1, m2;
    int         u0, r0;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        rst = 1'b1;
        clks(3);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_miso_oe", 32'(miso_oe_a), 32'd0);
        check("rst_miso", 32'(miso_a), 32'd0);
        check("rst_tx_ready", 32'(tx_ready_a), 32'd1);
        check("rst_rx_data", 32'(rx_data_a), 32'h00);
        check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
        check("rst_underrun", 32'(tx_underrun_a), 32'd0);
        rst = 1'b0;
        clks(10);

        // 1: loaded word 0xA5 out, 0xCE in
        a_write(8'hA5);
        check("t1_tx_ready_full", 32'(tx_ready_a), 32'd0);
        u0 = unr_cnt_a;
        exp_a_q.push_back(8'hCE);
        cs_n_a = 1'b0;
        clks(4);
        check("t1_tx_ready_load", 32'(tx_ready_a), 32'd1);
        check("t1_busy", 32'(busy_a), 32'd1);
        check("t1_miso_oe", 32'(miso_oe_a), 32'd1);
        a_bits(8'hCE, 8, mi);
        clks(1);
        cs_n_a = 1'b1;
        clks(8);
        check("t1_miso_word", 32'(mi), 32'hA5);
        check("t1_no_underrun", 32'(unr_cnt_a - u0), 32'd0);
        check("t1_busy_end", 32'(busy_a), 32'd0);
        check("t1_oe_end", 32'(miso_oe_a), 32'd0);

        // 2: underrun shifts DEFAULT_TX, reception still works
        u0 = unr_cnt_a;
        a_frame(8'h3A, mi);
        check("t2_miso_default", 32'(mi), 32'hFF);
        check("t2_underrun_once", 32'(unr_cnt_a - u0), 32'd1);

        // 3: back-to-back words, second TX word written mid-frame
        a_write(8'h3C);
        u0 = unr_cnt_a;
        exp_a_q.push_back(8'h12);
        exp_a_q.push_back(8'h34);
        cs_n_a = 1'b0;
        clks(4);
        fork
            a_bits(8'h12, 8, m1);
            begin
                clks(12);
                a_write(8'h81);
            end
        join
        a_bits(8'h34, 8, m2);
        clks(1);
        cs_n_a = 1'b1;
        clks(8);
        check("t3_miso_word0", 32'(m1), 32'h3C);
        check("t3_miso_word1", 32'(m2), 32'h81);
        check("t3_no_underrun", 32'(unr_cnt_a - u0), 32'd0);

        // 4: abort after 5 bits; partial TX word is not restored
        a_write(8'h0F);
        r0 = rx_cnt_a;
        cs_n_a = 1'b0;
        clks(4);
        a_bits(8'hB7, 5, mi);
        cs_n_a = 1'b1;
        clks(3);
        check("t4_busy_3clk", 32'(busy_a), 32'd0);
        check("t4_oe_3clk", 32'(miso_oe_a), 32'd0);
        check("t4_partial_miso", 32'(mi), 32'h08);
        clks(8);
        check("t4_no_rx_valid", 32'(rx_cnt_a - r0), 32'd0);
        check("t4_hold_empty", 32'(tx_ready_a), 32'd1);
        u0 = unr_cnt_a;
        a_frame(8'h5A, mi);
        check("t4_next_miso", 32'(mi), 32'hFF);
        check("t4_next_underrun", 32'(unr_cnt_a - u0), 32'd1);

        // 5: reset at bit 3, released with cs_n still low
        r0 = rx_cnt_a;
        cs_n_a = 1'b0;
        clks(4);
        a_bits(8'hE1, 3, mi);
        rst = 1'b1;
        clks(2);
        check("t5_rst_busy", 32'(busy_a), 32'd0);
        check("t5_rst_oe", 32'(miso_oe_a), 32'd0);
        check("t5_rst_rx_data", 32'(rx_data_a), 32'h00);
        check("t5_rst_tx_ready", 32'(tx_ready_a), 32'd1);
        rst = 1'b0;
        oe_seen_a = 1'b0;
        u0 = unr_cnt_a;
        a_bits(8'h0F, 5, mi);
        clks(6);
        check("t5_no_oe", 32'(oe_seen_a), 32'd0);
        check("t5_busy_low", 32'(busy_a), 32'd0);
        check("t5_no_underrun", 32'(unr_cnt_a - u0), 32'd0);
        check("t5_no_rx", 32'(rx_cnt_a - r0), 32'd0);
        cs_n_a = 1'b1;
        clks(8);
        a_write(8'h96);
        a_frame(8'hC3, mi);
        check("t5_after_miso", 32'(mi), 32'h96);

        // 6: CPHA=0 instance; mosi changes on trailing edges, samples on leading
        b_write(8'h80);
        exp_b_q.push_back(8'h55);
        cs_n_b = 1'b0;
        clks(4);
        check("t6_msb_early", 32'(miso_b), 32'd1);
        check("t6_oe_early", 32'(miso_oe_b), 32'd1);
        mi = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            mosi_b = 8'h55 >> i;
            clks(4);
            mi[i]  = miso_b;
            sclk_b = 1'b0;
            clks(4);
            sclk_b = 1'b1;
        end
        clks(4);
        cs_n_b = 1'b1;
        clks(8);
        check("t6_miso_word", 32'(mi), 32'h80);

        check("queue_a_drained", 32'(exp_a_q.size()), 32'd0);
        check("queue_b_drained", 32'(exp_b_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
